// File: rtl/decode_seq_ctrl.sv
// Decode-stage sequencer: HLT handling and interrupt entry through injected PUSH_FLAGS/PUSH_PC/JMP_VEC micro-ops.
// Optional macro DECODE_NESTED_INT_EN: nested interrupts via a 2-bit saturating ISR depth counter.
module decode_seq_ctrl #(
   parameter int unsigned IADDRW = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              handle_int,
   input  logic [7:0]        int_vector,
   input  logic              s0_halt_detect,
   input  logic              s0_iretd_detect,
   input  logic              s0_valid,
   input  logic              s0_ready,
   input  logic [IADDRW-1:0] s0_pc,
   output logic              dec_stall,
   output logic              halted,
   output logic              int_ack,
   output logic              inj_valid,
   output logic [1:0]        inj_uop,
   output logic [IADDRW-1:0] inj_data,
   output logic              in_isr
);

   typedef enum logic [2:0] {
      S_RUN,
      S_HALTED,
      S_INJ_FLAGS,
      S_INJ_PC,
      S_INJ_JMP
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [IADDRW-1:0] r_ret_pc;
   logic [7:0]        r_vec;
   logic              r_int_ack;
   logic              w_inj;
   logic              w_masked;
   logic              w_in_isr;
   logic              w_take_int;
   logic              w_accept;
   logic              w_iretd_acc;
   logic              w_halt_acc;
   logic              w_abort;

   assign w_inj      = (r_state == S_INJ_FLAGS) || (r_state == S_INJ_PC) || (r_state == S_INJ_JMP);
   assign w_take_int = !flush && handle_int && !w_masked &&
                       ((r_state == S_RUN) || (r_state == S_HALTED));
   // A taken interrupt preempts the stage-0 instruction, so it is not accepted that cycle.
   assign w_accept    = (r_state == S_RUN) && !flush && !w_take_int && s0_valid && s0_ready;
   assign w_iretd_acc = w_accept && s0_iretd_detect;
   assign w_halt_acc  = w_accept && s0_halt_detect && !s0_iretd_detect;
   assign w_abort     = w_inj && flush;

`ifdef DECODE_NESTED_INT_EN
   logic [1:0] r_isr_depth;

   // An aborted injection undoes the depth increment made on its entry.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_isr_depth <= '0;
      end else if (w_take_int) begin
         if (r_isr_depth != 2'd3) r_isr_depth <= r_isr_depth + 2'd1;
      end else if (w_iretd_acc || w_abort) begin
         if (r_isr_depth != 2'd0) r_isr_depth <= r_isr_depth - 2'd1;
      end
   end

   assign w_masked = (r_isr_depth == 2'd3);
   assign w_in_isr = (r_isr_depth != 2'd0);
`else
   logic r_in_isr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_in_isr <= 1'b0;
      end else if (w_take_int) begin
         r_in_isr <= 1'b1;
      end else if (w_iretd_acc || w_abort) begin
         r_in_isr <= 1'b0;
      end
   end

   assign w_masked = r_in_isr;
   assign w_in_isr = r_in_isr;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_RUN: begin
            if (w_take_int)      w_state_nxt = S_INJ_FLAGS;
            else if (w_halt_acc) w_state_nxt = S_HALTED;
         end
         S_HALTED: begin
            if (w_take_int) w_state_nxt = S_INJ_FLAGS;
         end
         S_INJ_FLAGS: begin
            if (flush)         w_state_nxt = S_RUN;
            else if (s0_ready) w_state_nxt = S_INJ_PC;
         end
         S_INJ_PC: begin
            if (flush)         w_state_nxt = S_RUN;
            else if (s0_ready) w_state_nxt = S_INJ_JMP;
         end
         S_INJ_JMP: begin
            if (flush || s0_ready) w_state_nxt = S_RUN;
         end
         default: w_state_nxt = S_RUN;
      endcase
   end

   // Return PC tracks the next PC of every accepted instruction; an interrupt with a
   // valid stage-0 instruction overrides it with that instruction's PC.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ret_pc  <= '0;
         r_vec     <= '0;
         r_int_ack <= 1'b0;
      end else begin
         r_int_ack <= w_take_int;
         if (w_take_int) begin
            r_vec <= int_vector;
            if ((r_state == S_RUN) && s0_valid) r_ret_pc <= s0_pc;
         end else if (w_accept) begin
            r_ret_pc <= s0_pc + 1'b1;
         end
      end
   end

   always_comb begin
      dec_stall = 1'b0;
      halted    = 1'b0;
      inj_valid = 1'b0;
      inj_uop   = 2'b00;
      inj_data  = '0;
      case (r_state)
         S_HALTED: begin
            dec_stall = 1'b1;
            halted    = 1'b1;
         end
         S_INJ_FLAGS: begin
            dec_stall = 1'b1;
            inj_valid = 1'b1;
            inj_uop   = 2'b01;
         end
         S_INJ_PC: begin
            dec_stall = 1'b1;
            inj_valid = 1'b1;
            inj_uop   = 2'b10;
            inj_data  = r_ret_pc;
         end
         S_INJ_JMP: begin
            dec_stall = 1'b1;
            inj_valid = 1'b1;
            inj_uop   = 2'b11;
            inj_data  = {{(IADDRW-11){1'b0}}, r_vec, 3'b000};
         end
         default: ;
      endcase
      int_ack = r_int_ack;
      in_isr  = w_in_isr;
   end

endmodule

// File: tb/tb_decode_seq_ctrl.sv
// Self-checking bench for decode_seq_ctrl: directed scenarios plus random stimulus against a behavioural model.
module tb_decode_seq_ctrl;
   localparam int unsigned AW = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          flush = 1'b0;
   logic          handle_int = 1'b0;
   logic [7:0]    int_vector = '0;
   logic          s0_halt_detect = 1'b0;
   logic          s0_iretd_detect = 1'b0;
   logic          s0_valid = 1'b0;
   logic          s0_ready = 1'b0;
   logic [AW-1:0] s0_pc = '0;
   logic          dec_stall, halted, int_ack, inj_valid, in_isr;
   logic [1:0]    inj_uop;
   logic [AW-1:0] inj_data;

   int n_checks = 0;
   int n_errors = 0;

   // Model: m_step counts injected micro-ops (0 = none, 1..3 = FLAGS/PC/JMP).
   int            m_step, m_depth;
   bit            m_hlt, m_ack;
   logic [AW-1:0] m_ret;
   logic [7:0]    m_vec;

   decode_seq_ctrl #(.IADDRW(AW)) dut (
      .clk(clk), .reset(reset), .flush(flush), .handle_int(handle_int),
      .int_vector(int_vector), .s0_halt_detect(s0_halt_detect),
      .s0_iretd_detect(s0_iretd_detect), .s0_valid(s0_valid), .s0_ready(s0_ready),
      .s0_pc(s0_pc), .dec_stall(dec_stall), .halted(halted), .int_ack(int_ack),
      .inj_valid(inj_valid), .inj_uop(inj_uop), .inj_data(inj_data), .in_isr(in_isr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [AW-1:0] act, input logic [AW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
      end
   endtask

   function automatic bit masked();
`ifdef DECODE_NESTED_INT_EN
      return m_depth == 3;
`else
      return m_depth != 0;
`endif
   endfunction

   task automatic model_reset();
      m_step = 0; m_depth = 0; m_hlt = 0; m_ack = 0; m_ret = '0; m_vec = '0;
   endtask

   task automatic enter_int();
      m_step = 1;
      m_depth++;
      m_vec = int_vector;
      m_ack = 1;
   endtask

   task automatic model_step();
      m_ack = 0;
      if (m_step != 0) begin
         if (flush) begin
            m_step = 0;
            if (m_depth > 0) m_depth--;
         end else if (s0_ready) begin
            m_step = (m_step == 3) ? 0 : m_step + 1;
         end
      end else if (m_hlt) begin
         if (!flush && handle_int && !masked()) begin
            m_hlt = 0;
            enter_int();
         end
      end else if (!flush) begin
         if (handle_int && !masked()) begin
            if (s0_valid) m_ret = s0_pc;
            enter_int();
         end else if (s0_valid && s0_ready) begin
            if (s0_iretd_detect) begin
               if (m_depth > 0) m_depth--;
            end else if (s0_halt_detect) begin
               m_hlt = 1;
            end
            m_ret = s0_pc + 1;
         end
      end
   endtask

   task automatic check_outputs();
      logic [AW-1:0] exp_data;
      exp_data = '0;
      if (m_step == 2) exp_data = m_ret;
      if (m_step == 3) exp_data = AW'(m_vec) << 3;
      chk("dec_stall", AW'(dec_stall), AW'(m_hlt || m_step != 0));
      chk("halted",    AW'(halted),    AW'(m_hlt));
      chk("int_ack",   AW'(int_ack),   AW'(m_ack));
      chk("inj_valid", AW'(inj_valid), AW'(m_step != 0));
      chk("inj_uop",   AW'(inj_uop),   AW'(m_step));
      chk("inj_data",  inj_data,       exp_data);
      chk("in_isr",    AW'(in_isr),    AW'(m_depth != 0));
   endtask

   task automatic tick(input logic f, input logic hi, input logic [7:0] v, input logic hd,
                       input logic id, input logic sv, input logic sr, input logic [AW-1:0] pc);
      @(negedge clk);
      flush = f; handle_int = hi; int_vector = v; s0_halt_detect = hd;
      s0_iretd_detect = id; s0_valid = sv; s0_ready = sr; s0_pc = pc;
      #1 check_outputs();
      @(posedge clk);
      model_step();
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_stall"}, AW'(dec_stall), '0);
      chk({tag, "_halted"}, AW'(halted), '0);
      chk({tag, "_ack"}, AW'(int_ack), '0);
      chk({tag, "_valid"}, AW'(inj_valid), '0);
      chk({tag, "_uop"}, AW'(inj_uop), '0);
      chk({tag, "_data"}, inj_data, '0);
      chk({tag, "_isr"}, AW'(in_isr), '0);
   endtask

   initial begin
      model_reset();
      #12 check_all_zero("rst");
      @(negedge clk) reset = 1'b1;

      // Plain flow, no events
      for (int i = 0; i < 6; i++) tick(0, 0, 8'h00, 0, 0, 1, 1, AW'(32'h10 + i));

      // HLT at 0x100, then interrupt vector 0x20
      tick(0, 0, 8'h00, 1, 0, 1, 1, AW'(32'h100));
      for (int i = 0; i < 3; i++) tick(0, 0, 8'h00, 0, 0, 1, 1, AW'(32'h101));
      tick(1, 0, 8'h00, 0, 0, 1, 1, AW'(32'h101));
      tick(0, 1, 8'h20, 0, 0, 1, 1, AW'(32'h101));
      for (int i = 0; i < 4; i++) tick(0, 0, 8'h55, 0, 0, 1, 1, AW'(32'h101));
      tick(0, 0, 8'h00, 0, 1, 1, 1, AW'(32'h300));

      // Interrupt at 0x200 with ready stalled during PUSH_PC
      tick(0, 1, 8'h07, 0, 0, 1, 1, AW'(32'h200));
      tick(0, 0, 8'h09, 0, 0, 1, 1, AW'(32'h200));
      for (int i = 0; i < 3; i++) tick(0, 0, 8'h0A, 0, 0, 1, 0, AW'(32'h200));
      for (int i = 0; i < 3; i++) tick(0, 0, 8'h00, 0, 0, 1, 1, AW'(32'h200));

      // Second interrupt while in ISR, then IRETDs
      tick(0, 1, 8'h31, 0, 0, 1, 1, AW'(32'h400));
      tick(0, 1, 8'h32, 0, 0, 1, 1, AW'(32'h500));
      for (int i = 0; i < 4; i++) tick(0, 0, 8'h00, 0, 0, 1, 1, AW'(32'h600));
      tick(0, 0, 8'h00, 1, 1, 1, 1, AW'(32'h700));
      tick(0, 0, 8'h00, 0, 1, 1, 1, AW'(32'h701));
      tick(0, 0, 8'h00, 0, 1, 1, 1, AW'(32'h702));

      // Flush and interrupt together, then flush mid-injection
      tick(1, 1, 8'h44, 0, 0, 1, 1, AW'(32'h800));
      tick(0, 1, 8'h44, 0, 0, 1, 1, AW'(32'h800));
      tick(0, 0, 8'h00, 0, 0, 1, 1, AW'(32'h800));
      tick(1, 0, 8'h00, 0, 0, 1, 1, AW'(32'h800));
      tick(0, 0, 8'h00, 0, 0, 1, 1, AW'(32'h801));

      // Return-PC wrap at all-ones
      tick(0, 0, 8'h00, 0, 0, 1, 1, '1);
      tick(0, 1, 8'h01, 0, 0, 0, 1, AW'(32'h5));
      for (int i = 0; i < 3; i++) tick(0, 0, 8'h00, 0, 0, 0, 1, AW'(32'h5));
      tick(0, 0, 8'h00, 0, 1, 1, 1, AW'(32'h6));

      // Reset asserted during PUSH_PC
      tick(0, 1, 8'h66, 0, 0, 1, 1, AW'(32'h900));
      tick(0, 0, 8'h00, 0, 0, 1, 1, AW'(32'h900));
      tick(0, 0, 8'h00, 0, 0, 1, 0, AW'(32'h900));
      #2 reset = 1'b0;
      #1 check_all_zero("midrst");
      model_reset();
      @(negedge clk) reset = 1'b1;
      tick(0, 0, 8'h00, 0, 0, 1, 1, AW'(32'hA00));

      for (int i = 0; i < 3000; i++) begin
         logic [AW-1:0] pc;
         pc = ($urandom_range(0, 15) == 0) ? '1 : AW'($urandom);
         tick($urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0, 8'($urandom),
              $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, pc);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
